// File: rtl/rx_frame_controller_if.sv
// Bundle between mac_receiver, the packet RAM write port and the USB-side descriptor consumer.
// The DUT uses the slave modport; the traffic source/consumer uses master.
interface rx_frame_controller_if #(
  parameter int ADDR_W = 11
);
  logic              wr_start;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              wr_error;
  logic              wr_end;
  logic              fifo_full;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_addr;
  logic [7:0]        buf_wr_data;
  logic              desc_valid;
  logic [ADDR_W-1:0] desc_addr;
  logic [10:0]       desc_len;
  logic              frame_release;
  logic [15:0]       frames_ok;
  logic [15:0]       frames_dropped;

  modport slave (
    input  wr_start, wr_en, wr_data, wr_error, wr_end, frame_release,
    output fifo_full, buf_wr_en, buf_wr_addr, buf_wr_data,
           desc_valid, desc_addr, desc_len, frames_ok, frames_dropped
  );

  modport master (
    output wr_start, wr_en, wr_data, wr_error, wr_end, frame_release,
    input  fifo_full, buf_wr_en, buf_wr_addr, buf_wr_data,
           desc_valid, desc_addr, desc_len, frames_ok, frames_dropped
  );
endinterface

// File: rtl/rx_frame_controller.sv
// Store-and-forward sequencer: writes frames into a circular packet RAM, commits good
// frames as descriptors, rolls back bad ones and frees space on USB-side release.
module rx_frame_controller #(
  parameter int ADDR_W     = 11,
  parameter int MAX_LEN    = 1518,
  parameter int MIN_LEN    = 64,
  parameter int DESC_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 n_reset,
  rx_frame_controller_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam int QW = $clog2(DESC_DEPTH);
  localparam logic [QW:0] Q_ONE = 1;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT, DROP} state_t;

  state_t            state_q;
  logic [PW-1:0]     wp_q, cp_q, rp_q, cp_d;
  logic [10:0]       len_q, len_d;
  logic              ovf_q, ovf_d, byte_ok, frame_bad;
  logic              buf_wr_en_q;
  logic [ADDR_W-1:0] buf_wr_addr_q;
  logic [7:0]        buf_wr_data_q;
  logic [15:0]       ok_q, drop_q;
  logic [ADDR_W-1:0] dq_addr_q [DESC_DEPTH];
  logic [10:0]       dq_len_q  [DESC_DEPTH];
  logic [QW:0]       head_q, tail_q;
  logic [QW-1:0]     head_idx, tail_idx;
  logic              buf_full, dq_full, dq_empty, pop;

  assign head_idx = head_q[QW-1:0];
  assign tail_idx = tail_q[QW-1:0];
  // used == 2^ADDR_W exactly when the wrap bits differ and the low bits agree
  assign buf_full = (cp_q[ADDR_W] != rp_q[ADDR_W]) && (cp_q[ADDR_W-1:0] == rp_q[ADDR_W-1:0]);
  assign dq_empty = (head_q == tail_q);
  assign dq_full  = (head_idx == tail_idx) && (head_q[QW] != tail_q[QW]);
  assign pop      = bus.frame_release && !dq_empty;

  always_comb begin
    byte_ok = 1'b0;
    cp_d    = cp_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (state_q == RECV && bus.wr_en && !bus.wr_start && !bus.wr_error) begin
      if (!buf_full && (len_q < 11'(MAX_LEN))) begin
        byte_ok = 1'b1;
        cp_d    = cp_q + PW'(1);
        len_d   = len_q + 11'd1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // judged on the post-byte length so a byte arriving with wr_end is counted
  assign frame_bad = ovf_d || (len_d < 11'(MIN_LEN)) || dq_full;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      wp_q          <= '0;
      cp_q          <= '0;
      rp_q          <= '0;
      len_q         <= '0;
      ovf_q         <= 1'b0;
      buf_wr_en_q   <= 1'b0;
      buf_wr_addr_q <= '0;
      buf_wr_data_q <= '0;
      ok_q          <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      for (int unsigned i = 0; i < DESC_DEPTH; i++) begin
        dq_addr_q[i] <= '0;
        dq_len_q[i]  <= '0;
      end
    end else begin
      buf_wr_en_q <= byte_ok;
      if (byte_ok) begin
        buf_wr_addr_q <= cp_q[ADDR_W-1:0];
        buf_wr_data_q <= bus.wr_data;
      end
      cp_q  <= cp_d;
      len_q <= len_d;
      ovf_q <= ovf_d;
      if (pop) begin
        rp_q   <= rp_q + PW'(dq_len_q[head_idx]);
        head_q <= head_q + Q_ONE;
      end
      case (state_q)
        IDLE: begin
          if (bus.wr_start) begin
            cp_q    <= wp_q;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (bus.wr_start) begin
            cp_q   <= wp_q;
            len_q  <= '0;
            ovf_q  <= 1'b0;
            drop_q <= sat_inc(drop_q);
          end else if (bus.wr_error) begin
            if (bus.wr_end) begin
              cp_q    <= wp_q;
              drop_q  <= sat_inc(drop_q);
              state_q <= IDLE;
            end else begin
              state_q <= DROP;
            end
          end else if (bus.wr_end) begin
            if (frame_bad) begin
              cp_q    <= wp_q;
              drop_q  <= sat_inc(drop_q);
              state_q <= IDLE;
            end else begin
              state_q <= COMMIT;
            end
          end
        end
        COMMIT: begin
          dq_addr_q[tail_idx] <= wp_q[ADDR_W-1:0];
          dq_len_q[tail_idx]  <= len_q;
          tail_q              <= tail_q + Q_ONE;
          wp_q                <= cp_q;
          ok_q                <= sat_inc(ok_q);
          state_q             <= IDLE;
        end
        DROP: begin
          if (bus.wr_end) begin
            cp_q    <= wp_q;
            drop_q  <= sat_inc(drop_q);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fifo_full      = buf_full | dq_full;
  assign bus.buf_wr_en      = buf_wr_en_q;
  assign bus.buf_wr_addr    = buf_wr_addr_q;
  assign bus.buf_wr_data    = buf_wr_data_q;
  assign bus.desc_valid     = !dq_empty;
  assign bus.desc_addr      = dq_addr_q[head_idx];
  assign bus.desc_len       = dq_len_q[head_idx];
  assign bus.frames_ok      = ok_q;
  assign bus.frames_dropped = drop_q;
endmodule

// File: tb/tb_rx_frame_controller.sv
// Directed bench for rx_frame_controller: a frame-level model predicts RAM writes,
// descriptors, counters and fifo_full; a 2 KiB and a 128 B instance share the stimulus.
module tb_rx_frame_controller;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  localparam int DEPTH   = 4;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       sel = 1'b0;
  logic       wr_start = 1'b0, wr_en = 1'b0, wr_error = 1'b0, wr_end = 1'b0;
  logic       frame_release = 1'b0;
  logic [7:0] wr_data = 8'h00;

  always #5 clk = ~clk;

  rx_frame_controller_if #(.ADDR_W(11)) bus_l ();
  rx_frame_controller_if #(.ADDR_W(7))  bus_s ();

  assign bus_l.wr_start      = wr_start & ~sel;
  assign bus_l.wr_en         = wr_en & ~sel;
  assign bus_l.wr_error      = wr_error & ~sel;
  assign bus_l.wr_end        = wr_end & ~sel;
  assign bus_l.frame_release = frame_release & ~sel;
  assign bus_l.wr_data       = wr_data;
  assign bus_s.wr_start      = wr_start & sel;
  assign bus_s.wr_en         = wr_en & sel;
  assign bus_s.wr_error      = wr_error & sel;
  assign bus_s.wr_end        = wr_end & sel;
  assign bus_s.frame_release = frame_release & sel;
  assign bus_s.wr_data       = wr_data;

  rx_frame_controller #(.ADDR_W(11), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .DESC_DEPTH(DEPTH))
    dut_l (.clk(clk), .n_reset(n_reset), .bus(bus_l.slave));
  rx_frame_controller #(.ADDR_W(7), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .DESC_DEPTH(DEPTH))
    dut_s (.clk(clk), .n_reset(n_reset), .bus(bus_s.slave));

  logic        o_wen, o_full, o_dvalid;
  logic [10:0] o_waddr, o_daddr, o_dlen;
  logic [7:0]  o_wdata;
  logic [15:0] o_ok, o_drop;

  always_comb begin
    if (sel) begin
      o_wen = bus_s.buf_wr_en;   o_waddr = {4'b0, bus_s.buf_wr_addr}; o_wdata = bus_s.buf_wr_data;
      o_full = bus_s.fifo_full;  o_dvalid = bus_s.desc_valid;
      o_daddr = {4'b0, bus_s.desc_addr}; o_dlen = bus_s.desc_len;
      o_ok = bus_s.frames_ok;    o_drop = bus_s.frames_dropped;
    end else begin
      o_wen = bus_l.buf_wr_en;   o_waddr = bus_l.buf_wr_addr; o_wdata = bus_l.buf_wr_data;
      o_full = bus_l.fifo_full;  o_dvalid = bus_l.desc_valid;
      o_daddr = bus_l.desc_addr; o_dlen = bus_l.desc_len;
      o_ok = bus_l.frames_ok;    o_drop = bus_l.frames_dropped;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: byte positions as unbounded integers, addresses taken modulo buffer size.
  typedef struct {int addr; int data;} wr_t;
  typedef struct {int addr; int len;}  desc_t;
  wr_t   exp_w[$];
  desc_t m_q[$];
  wr_t   w;
  int    m_size, m_wp, m_rp, m_len, m_ok, m_drop;
  bit    m_ovf, m_err, m_active;
  bit    settled = 1'b0;
  int    wcount = 0;

  function automatic void model_clear();
    m_size = sel ? 128 : 2048;
    m_wp = 0; m_rp = 0; m_len = 0; m_ok = 0; m_drop = 0;
    m_ovf = 0; m_err = 0; m_active = 0;
    exp_w.delete();
    m_q.delete();
  endfunction

  function automatic void model_finish();
    desc_t d;
    if (m_err || m_ovf || m_len < MIN_LEN || m_q.size() == DEPTH) begin
      m_drop++;
    end else begin
      d.addr = m_wp % m_size;
      d.len  = m_len;
      m_q.push_back(d);
      m_wp += m_len;
      m_ok++;
    end
    m_active = 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    wr_start = 0; wr_en = 0; wr_error = 0; wr_end = 0; frame_release = 0;
  endtask

  task automatic start_frame();
    tick();
    settled = 0;
    wr_start = 1;
    if (m_active) m_drop++;
    m_active = 1; m_len = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit err, input bit last);
    wr_t t;
    tick();
    settled = 0;
    wr_en = 1; wr_data = d; wr_error = err; wr_end = last;
    if (err) begin
      m_err = 1;
    end else if (!m_err) begin
      if ((m_wp + m_len - m_rp) < m_size && m_len < MAX_LEN) begin
        t.addr = (m_wp + m_len) % m_size;
        t.data = int'(d);
        exp_w.push_back(t);
        m_len++;
      end else begin
        m_ovf = 1;
      end
    end
    if (last) model_finish();
  endtask

  task automatic end_frame();
    tick();
    settled = 0;
    wr_end = 1;
    model_finish();
  endtask

  task automatic release_frame();
    tick();
    settled = 0;
    frame_release = 1;
    if (m_q.size() != 0) begin
      m_rp += m_q[0].len;
      void'(m_q.pop_front());
    end
  endtask

  task automatic settle();
    repeat (3) tick();
    settled = 1;
  endtask

  task automatic send_frame(input int n, input int base, input bit end_with_byte);
    start_frame();
    for (int i = 0; i < n; i++)
      send_byte(8'(base + i), 1'b0, end_with_byte && (i == n - 1));
    if (!end_with_byte) end_frame();
    settle();
  endtask

  task automatic do_reset(input logic to_sel);
    tick();
    settled = 0;
    #2;
    n_reset = 0;
    sel = to_sel;
    model_clear();
    #1;
    check("rst_buf_wr_en", o_wen, 0);
    check("rst_buf_wr_addr", o_waddr, 0);
    check("rst_buf_wr_data", o_wdata, 0);
    check("rst_fifo_full", o_full, 0);
    check("rst_desc_valid", o_dvalid, 0);
    check("rst_desc_addr", o_daddr, 0);
    check("rst_desc_len", o_dlen, 0);
    check("rst_frames_ok", o_ok, 0);
    check("rst_frames_dropped", o_drop, 0);
    @(negedge clk);
    n_reset = 1;
    tick();
    settled = 1;
  endtask

  // Per-cycle comparison of the write stream and, when idle, of the descriptor/counter view.
  always @(negedge clk) begin
    if (n_reset) begin
      if (o_wen) begin
        wcount++;
        check("wr_expected", exp_w.size() != 0, 1);
        if (exp_w.size() != 0) begin
          w = exp_w.pop_front();
          check("wr_addr", o_waddr, w.addr);
          check("wr_data", o_wdata, w.data);
        end
      end
      if (settled) begin
        check("desc_valid", o_dvalid, m_q.size() != 0);
        if (m_q.size() != 0) begin
          check("desc_addr", o_daddr, m_q[0].addr);
          check("desc_len", o_dlen, m_q[0].len);
        end
        check("frames_ok", o_ok, m_ok);
        check("frames_dropped", o_drop, m_drop);
        check("fifo_full", o_full, ((m_wp - m_rp) == m_size) || (m_q.size() == DEPTH));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;

    // 1: single 64-byte frame and descriptor latency
    do_reset(1'b0);
    start_frame();
    for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0, 1'b0);
    end_frame();
    tick();
    check("t1_valid_wr_end_plus1", o_dvalid, 0);
    tick();
    check("t1_valid_wr_end_plus2", o_dvalid, 1);
    settle();
    check("t1_desc_addr", o_daddr, 0);
    check("t1_desc_len", o_dlen, 64);
    check("t1_frames_ok", o_ok, 1);
    release_frame();
    settle();

    // 2: error mid-frame rolls back; restart via wr_start aborts
    do_reset(1'b0);
    start_frame();
    for (int i = 0; i < 64; i++) send_byte(8'(8'hA0 + i), i >= 10, 1'b0);
    end_frame();
    settle();
    check("t2_dropped", o_drop, 1);
    check("t2_no_desc", o_dvalid, 0);
    send_frame(64, 8'h11, 1'b0);
    check("t2_next_addr", o_daddr, 0);
    check("t2_next_len", o_dlen, 64);
    start_frame();
    for (int i = 0; i < 10; i++) send_byte(8'(8'h50 + i), 1'b0, 1'b0);
    send_frame(64, 8'h70, 1'b0);
    check("t2_abort_dropped", o_drop, 2);
    check("t2_abort_ok", o_ok, 2);

    // 3: runts, oversize, exact MAX_LEN
    do_reset(1'b0);
    send_frame(40, 0, 1'b0);
    check("t3_runt40", o_drop, 1);
    send_frame(63, 3, 1'b1);
    check("t3_runt63", o_drop, 2);
    wc0 = wcount;
    send_frame(MAX_LEN + 1, 7, 1'b0);
    check("t3_ovf_writes", wcount - wc0, MAX_LEN);
    check("t3_ovf_dropped", o_drop, 3);
    send_frame(MAX_LEN, 9, 1'b1);
    check("t3_max_ok", o_ok, 1);
    check("t3_max_len", o_dlen, MAX_LEN);
    release_frame();
    settle();

    // 4: descriptor queue full
    do_reset(1'b0);
    for (int f = 0; f < 4; f++) send_frame(64 + f, f * 16, 1'b0);
    check("t4_fifo_full", o_full, 1);
    send_frame(64, 8'hEE, 1'b0);
    check("t4_fifth_dropped", o_drop, 1);
    release_frame();
    settle();
    check("t4_fifo_free", o_full, 0);
    check("t4_desc_addr", o_daddr, 64);
    check("t4_desc_len", o_dlen, 65);

    // 5: 128-byte instance, wrap and buffer overflow
    do_reset(1'b1);
    send_frame(100, 0, 1'b0);
    release_frame();
    settle();
    send_frame(64, 8'h80, 1'b0);
    check("t5_wrap_addr", o_daddr, 100);
    check("t5_wrap_len", o_dlen, 64);
    release_frame();
    settle();
    wc0 = wcount;
    send_frame(130, 8'h20, 1'b0);
    check("t5_full_writes", wcount - wc0, 128);
    check("t5_full_dropped", o_drop, 1);

    // 6: reset mid-frame
    do_reset(1'b0);
    send_frame(64, 8'h33, 1'b0);
    start_frame();
    for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 1'b0, 1'b0);
    do_reset(1'b0);
    send_frame(64, 8'h44, 1'b0);
    check("t6_addr_after_reset", o_daddr, 0);
    check("t6_ok_after_reset", o_ok, 1);

    tick();
    tick();
    check("wr_drained", exp_w.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
- Store-and-forward sequencer between mac_receiver's write interface and the RX packet RAM that feeds the USB side.
- Writes each frame's bytes into a circular byte buffer. Commits good frames as descriptors. Rolls back frames that are errored, runt, oversize or overflowing.
- Drives fifo_full back to mac_receiver and frees buffer space when the USB side releases a frame.

Parameters:
- ADDR_W, 11, packet RAM address width (buffer = 2^ADDR_W bytes).
- MAX_LEN, 1518, maximum accepted frame length in bytes, preamble/SFD excluded.
- MIN_LEN, 64, minimum accepted frame length in bytes.
- DESC_DEPTH, 4, descriptor queue entries (power of 2).

Ports:
- clk  in  1  system clock.
- n_reset  in  1  asynchronous active-low reset.
- wr_start  in  1  from mac_receiver: first data byte of a frame follows.
- wr_en  in  1  from mac_receiver: wr_data valid this cycle.
- wr_data  in  8  from mac_receiver: frame byte.
- wr_error  in  1  from mac_receiver: rxer seen in the current frame.
- wr_end  in  1  from mac_receiver: rxdv deasserted, frame finished.
- fifo_full  out  1  to mac_receiver: buffer or descriptor queue has no room.
- buf_wr_en  out  1  packet RAM write strobe.
- buf_wr_addr  out  ADDR_W  packet RAM write address.
- buf_wr_data  out  8  packet RAM write data.
- desc_valid  out  1  head descriptor available.
- desc_addr  out  ADDR_W  head frame start address.
- desc_len  out  11  head frame length in bytes.
- frame_release  in  1  USB side: head frame consumed, pop it.
- frames_ok  out  16  committed frame count.
- frames_dropped  out  16  dropped frame count.

Behaviour:
- Reset (async, n_reset=0): state IDLE; all pointers, len, counters and descriptor queue cleared. All outputs 0.
- Pointers are ADDR_W+1 bits (wrap bit):
  - wp: committed write pointer.
  - cp: current write pointer.
  - rp: release pointer.
  - used = cp - rp; full when used == 2^ADDR_W.
  - Addresses use the low ADDR_W bits and wrap modulo 2^ADDR_W.
- FSM states: IDLE, RECV, COMMIT, DROP.
- IDLE:
  - On wr_start: cp<=wp, len<=0, ovf<=0, go to RECV.
  - wr_en/wr_end without wr_start are ignored.
- RECV, on each wr_en:
  - If not full and len < MAX_LEN: write the byte to RAM at cp; cp++, len++.
  - Otherwise set ovf; no RAM write.
  - RAM write is registered: buf_wr_* valid the cycle after wr_en.
- RECV exits (priority in this order):
  1. wr_start while in RECV: abort the current frame (counts as a drop), restart per IDLE rule.
  2. wr_error=1: go to DROP; remaining bytes ignored.
  3. wr_end with no error: byte on the same cycle (wr_en with wr_end) is counted first. Then:
     - If wr_error, ovf, len < MIN_LEN, or descriptor queue full: rollback.
     - Else go to COMMIT.
- DROP: ignore wr_en until wr_end, then rollback.
- Rollback (one cycle): cp<=wp, frames_dropped++, go to IDLE.
- COMMIT (one cycle): push {wp, len}; wp<=cp; frames_ok++; go to IDLE. desc_valid rises 2 cycles after the wr_end cycle when the queue was empty.
- Descriptor queue: first-word fall-through; desc_* show the head entry while desc_valid=1.
- frame_release:
  - With desc_valid=1: rp<=rp+desc_len, pop the queue.
  - With desc_valid=0: ignored.
  - Push and pop on the same cycle are both honoured; occupancy is unchanged.
- fifo_full = full OR descriptor queue full (combinational). mac_receiver behaviour under fifo_full is its own concern; this block still protects itself via ovf.
- Counters saturate at 16'hFFFF.
- Frame length exactly MAX_LEN is accepted. MAX_LEN+1 bytes sets ovf and the frame is dropped.
- A frame that spans the RAM end wraps the address; desc_addr plus len wraps accordingly.

Test Plan:
1. Reset, then a 64-byte frame (wr_start, 64x wr_en with data 0x00..0x3F, wr_end) -> buf_wr_addr 0..63 with matching data, desc_valid=1 with desc_addr=0 and desc_len=64, frames_ok=1.
2. wr_error asserted on byte 10 of a 64-byte frame -> no descriptor, wp stays 0, frames_dropped=1. The next good 64-byte frame starts at address 0.
3. 40-byte frame -> runt drop, frames_dropped=1. A 1519-byte frame (MAX_LEN=1518) -> ovf, dropped, only 1518 RAM writes.
4. Commit 4 frames without release (DESC_DEPTH=4) -> fifo_full=1 and a 5th frame is dropped. One frame_release -> fifo_full=0 and desc_addr advances by the first frame's length.
5. ADDR_W=7 (128 B): commit 100 B, release it, then receive 64 B -> writes wrap through address 127 to 0, desc_addr=100, desc_len=64.
6. n_reset pulsed low mid-frame after 20 bytes -> all outputs 0 immediately, desc_valid=0. The next frame writes from address 0.
